// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module   : inst_fetch_queue
// Brief    : RV32I fetch stage - owns the fetch PC, reads the ROM and buffers
//            {pc, instr} pairs in a prefetch FIFO handed to decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              rom_addr,
    input  logic [31:0]              rom_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst_data,
    output logic [31:0]              inst_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    logic [31:0]         r_fpc;
    logic [c_ADDR_W-1:0] r_wptr;
    logic [c_ADDR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [31:0]         r_pc_mem    [DEPTH];
    logic [31:0]         r_instr_mem [DEPTH];

    logic                w_full;
    logic                w_enq;
    logic                w_deq;
    logic                w_wr_en;
    logic [31:0]         w_target;

    // Full is judged on the registered count, so a dequeue never frees a slot
    // for an enqueue in the same cycle.
    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    assign w_enq      = !w_full;
    assign w_deq      = inst_valid && inst_ready;
    assign w_wr_en    = !reset && !redirect_valid && w_enq;
    assign w_target   = redirect_pc & 32'hFFFF_FFFC;

    assign rom_addr   = r_fpc;
    assign inst_valid = (r_count != '0);
    assign inst_data  = inst_valid ? r_instr_mem[r_rptr] : 32'h0;
    assign inst_pc    = inst_valid ? r_pc_mem[r_rptr]    : 32'h0;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc   <= RESET_PC;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_fpc   <= w_target;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_fpc  <= r_fpc + 32'd4;
                r_wptr <= r_wptr + c_ADDR_W'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + c_ADDR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_pc_mem[r_wptr]    <= r_fpc;
            r_instr_mem[r_wptr] <= rom_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// Module   : tb_inst_fetch_queue
// Brief    : Directed + random self-checking bench for inst_fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [2:0]  fifo_count;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sbq [$];
    logic [31:0] m_fpc;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fifo_count     (fifo_count)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare outputs against the model, drive one cycle of stimulus and
    // advance the model (fetches pushed, accepted heads popped).
    task automatic step(input bit rst, input bit redir, input bit rdy,
                        input logic [31:0] rpc, input bit do_chk);
        logic [31:0] ep;
        logic [31:0] ed;
        bit          enq;
        bit          deq;
        if (do_chk) begin
            ep = (sbq.size() != 0) ? sbq[0][63:32] : 32'h0;
            ed = (sbq.size() != 0) ? sbq[0][31:0]  : 32'h0;
            chk32("rom_addr",   rom_addr, m_fpc);
            chk32("inst_valid", {31'b0, inst_valid}, {31'b0, (sbq.size() != 0)});
            chk32("inst_pc",    inst_pc, ep);
            chk32("inst_data",  inst_data, ed);
            chk32("fifo_count", {29'b0, fifo_count}, 32'(sbq.size()));
        end
        reset          = rst;
        redirect_valid = redir;
        inst_ready     = rdy;
        redirect_pc    = rpc;
        if (rst) begin
            m_fpc = 32'h0;
            sbq.delete();
        end else if (redir) begin
            m_fpc = {rpc[31:2], 2'b00};
            sbq.delete();
        end else begin
            enq = (sbq.size() != 4);
            deq = (sbq.size() != 0) && rdy;
            if (deq) void'(sbq.pop_front());
            if (enq) begin
                sbq.push_back({m_fpc, rom_word(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        m_fpc          = 32'h0;
        @(negedge clk);

        // Reset values, then streaming with ready held high
        step(1, 0, 0, 32'h0, 0);
        step(1, 0, 1, 32'h0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h0, 1);
        chk32("stream_pc", inst_pc, 32'h1C);

        // Stall ten cycles, FIFO fills and fetch stops at 0x10
        step(1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 32'h0, 1);
        chk32("full_rom_addr", rom_addr, 32'h10);
        chk32("full_count", {29'b0, fifo_count}, 32'd4);
        chk32("full_head_pc", inst_pc, 32'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 1);

        // Redirect from a full FIFO
        step(0, 1, 0, 32'h40, 1);
        chk32("redir_valid", {31'b0, inst_valid}, 32'd0);
        chk32("redir_rom_addr", rom_addr, 32'h40);
        step(0, 0, 0, 32'h0, 1);
        chk32("redir_pc", inst_pc, 32'h40);
        chk32("redir_data", inst_data, 32'h1000_0010);

        // Misaligned target and PC wraparound
        step(0, 1, 1, 32'h43, 1);
        chk32("align_rom_addr", rom_addr, 32'h40);
        step(0, 0, 1, 32'h0, 1);
        step(0, 1, 1, 32'hFFFF_FFFC, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h0, 1);

        // Back-to-back redirects, only the last one is fetched
        step(0, 1, 1, 32'h100, 1);
        step(0, 1, 1, 32'h200, 1);
        step(0, 1, 1, 32'h300, 1);
        step(0, 0, 1, 32'h0, 1);
        chk32("b2b_pc", inst_pc, 32'h300);
        step(0, 0, 1, 32'h0, 1);

        // Reset wins over redirect, even with a live handshake
        chk32("pre_rst_valid", {31'b0, inst_valid}, 32'd1);
        step(1, 1, 1, 32'h80, 1);
        chk32("rst_redir_addr", rom_addr, 32'h0);
        chk32("rst_redir_cnt", {29'b0, fifo_count}, 32'd0);
        step(0, 0, 1, 32'h0, 1);

        // Random back-pressure
        for (int i = 0; i < 200; i++) begin
            step(0, 0, 1'($urandom_range(0, 1)), 32'h0, 1);
            chk32("count_bound", {31'b0, (fifo_count <= 3'd4)}, 32'd1);
        end
        step(0, 0, 0, 32'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
